// File: rtl/data_sram_responder.sv
// data_sram_responder
//   Far-side responder for the CPU data SRAM port. Serves every access in fixed
//   time: word-addressed RAM with byte-lane writes and a 1-cycle registered read,
//   plus a 4-register MMIO page (LED, synchronised switches, timer, status).
// Ports:
//   clk, resetn          - clock, asynchronous active-low reset
//   data_sram_en/we      - access request / byte-lane write enables (we==0 is a read)
//   data_sram_addr/wdata - byte address (bits [1:0] ignored) / lane-aligned store data
//   data_sram_rdata      - registered read data, held between reads
//   led                  - LED register
//   switch               - asynchronous board switches
//   oob_err              - sticky out-of-range RAM access flag
module data_sram_responder #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  input  logic [7:0]  switch,
  output logic        oob_err
);

  localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  localparam logic [1:0] OFF_LED    = 2'd0;
  localparam logic [1:0] OFF_SWITCH = 2'd1;
  localparam logic [1:0] OFF_TIMER  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  logic [31:0] r_mem [RAM_WORDS];
  logic [31:0] r_rdata;
  logic [15:0] r_led;
  logic [31:0] r_timer;
  logic        r_oob_err;
  logic [7:0]  r_sw_meta;
  logic [7:0]  r_sw_sync;

  logic [29:0]   w_ram_idx;
  logic [AW-1:0] w_ram_addr;
  logic          w_is_mmio;
  logic          w_mmio_mapped;
  logic [1:0]    w_off;
  logic          w_is_rd;
  logic          w_is_wr;
  logic          w_in_range;
  logic          w_ram_wr;
  logic          w_oob;
  logic          w_led_wr;
  logic          w_timer_wr;
  logic          w_status_clr;
  logic [31:0]   w_rd_val;
  logic [31:0]   w_timer_d;
  logic          w_unused_addr;

  assign w_ram_idx     = data_sram_addr[31:2];
  assign w_ram_addr    = w_ram_idx[AW-1:0];
  assign w_is_mmio     = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign w_mmio_mapped = w_is_mmio && (data_sram_addr[15:4] == 12'd0);
  assign w_off         = data_sram_addr[3:2];
  assign w_is_rd       = data_sram_en && (data_sram_we == 4'd0);
  assign w_is_wr       = data_sram_en && (data_sram_we != 4'd0);
  assign w_in_range    = ({2'b00, w_ram_idx} < RAM_WORDS);
  assign w_unused_addr = ^data_sram_addr[1:0];

  assign w_ram_wr      = w_is_wr && !w_is_mmio && w_in_range;
  // Any RAM-space access (read or write) beyond the array flags an error.
  assign w_oob         = data_sram_en && !w_is_mmio && !w_in_range;
  assign w_led_wr      = w_is_wr && w_mmio_mapped && (w_off == OFF_LED);
  assign w_timer_wr    = w_is_wr && w_mmio_mapped && (w_off == OFF_TIMER);
  assign w_status_clr  = w_is_wr && w_mmio_mapped && (w_off == OFF_STATUS) &&
                         data_sram_we[0] && data_sram_wdata[0];

  // RAM array: deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) r_mem[w_ram_addr][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_rd_val = 32'd0;
    if (w_is_mmio) begin
      if (w_mmio_mapped) begin
        unique case (w_off)
          OFF_LED:    w_rd_val = {16'd0, r_led};
          OFF_SWITCH: w_rd_val = {24'd0, r_sw_sync};
          OFF_TIMER:  w_rd_val = r_timer;
          OFF_STATUS: w_rd_val = {31'd0, r_oob_err};
          default:    w_rd_val = 32'd0;
        endcase
      end
    end else if (w_in_range) begin
      w_rd_val = r_mem[w_ram_addr];
    end
  end

  // A timer write replaces the enabled bytes and suppresses that cycle's increment.
  always_comb begin
    w_timer_d = r_timer + 32'd1;
    if (w_timer_wr) begin
      w_timer_d = r_timer;
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) w_timer_d[8*i +: 8] = data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata   <= 32'd0;
      r_led     <= 16'd0;
      r_timer   <= 32'd0;
      r_oob_err <= 1'b0;
      r_sw_meta <= 8'd0;
      r_sw_sync <= 8'd0;
    end else begin
      if (w_is_rd) r_rdata <= w_rd_val;
      if (w_led_wr) begin
        if (data_sram_we[0]) r_led[7:0]  <= data_sram_wdata[7:0];
        if (data_sram_we[1]) r_led[15:8] <= data_sram_wdata[15:8];
      end
      r_timer   <= w_timer_d;
      // Set has priority over the W1C clear.
      if (w_oob) begin
        r_oob_err <= 1'b1;
      end else if (w_status_clr) begin
        r_oob_err <= 1'b0;
      end
      r_sw_meta <= switch;
      r_sw_sync <= r_sw_meta;
    end
  end

  assign data_sram_rdata = r_rdata;
  assign led             = r_led;
  assign oob_err         = r_oob_err;

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

  logic        clk;
  logic        resetn;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [7:0]  sw;
  logic        oob;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  localparam logic [31:0] MB = 32'hBFAF_0000;

  data_sram_responder #(
    .RAM_WORDS(1024),
    .MMIO_BASE(32'hBFAF_0000)
  ) u_dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (en),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .led             (led),
    .switch          (sw),
    .oob_err         (oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every sampled read pops one expected value.
  always @(posedge clk) begin
    if (resetn && en && we == 4'd0) begin
      #1;
      if (exp_q.size() == 0) begin
        check("sb_underflow", rdata, 32'hxxxx_xxxx);
      end else begin
        check(tag_q.pop_front(), rdata, exp_q.pop_front());
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; we = w; addr = a; wdata = d;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
    @(negedge clk);
    en = 1'b1; we = 4'd0; addr = a; wdata = 32'd0;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b0; we = 4'd0;
    end
  endtask

  initial begin
    resetn = 1'b0; en = 1'b0; we = 4'd0; addr = 32'd0; wdata = 32'd0; sw = 8'd0;
    #12;
    check("rst_rdata", rdata, 32'd0);
    check("rst_led", {16'd0, led}, 32'd0);
    check("rst_oob", {31'd0, oob}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Basic word write/read and hold across idle cycles
    wr(32'h0000_0010, 4'hF, 32'h1234_5678);
    rd(32'h0000_0010, 32'h1234_5678, "ram_rd");
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("rdata_hold", rdata, 32'h1234_5678);
    end

    // Lane merge, read immediately after write
    wr(32'h0000_0010, 4'b0101, 32'hAABB_CCDD);
    rd(32'h0000_0010, 32'h12BB_56DD, "lane_merge");
    // Read data holds across a write
    wr(32'h0000_0020, 4'hF, 32'h0BAD_0BAD);
    idle(1);
    check("rdata_hold_wr", rdata, 32'h12BB_56DD);

    // LED
    wr(MB, 4'hF, 32'hFFFF_A5A5);
    idle(1);
    check("led_out", {16'd0, led}, 32'h0000_A5A5);
    rd(MB, 32'h0000_A5A5, "led_rd");
    wr(MB, 4'b0010, 32'h0000_3C00);
    rd(MB, 32'h0000_3CA5, "led_lane1");

    // SWITCH through synchroniser; writes ignored
    sw = 8'h3C;
    idle(3);
    rd(MB + 32'h4, 32'h0000_003C, "switch_rd");
    wr(MB + 32'h4, 4'hF, 32'h0000_0000);
    rd(MB + 32'h4, 32'h0000_003C, "switch_ro");

    // Timer wrap
    wr(MB + 32'h8, 4'hF, 32'hFFFF_FFFE);
    idle(2);
    rd(MB + 32'h8, 32'h0000_0000, "timer_wrap");
    // Timer counting: reads 5 cycles apart differ by 5
    wr(MB + 32'h8, 4'hF, 32'h0000_0100);
    rd(MB + 32'h8, 32'h0000_0100, "timer_t0");
    idle(4);
    rd(MB + 32'h8, 32'h0000_0105, "timer_t5");

    // Out-of-range access
    wr(32'h0000_0000, 4'hF, 32'hCAFE_F00D);
    idle(1);
    check("oob_clear_init", {31'd0, oob}, 32'd0);
    wr(32'h0000_1000, 4'hF, 32'hDEAD_BEEF);
    idle(1);
    check("oob_set", {31'd0, oob}, 32'd1);
    rd(32'h0000_0000, 32'hCAFE_F00D, "oob_no_alias");
    rd(32'h0000_1000, 32'h0000_0000, "oob_rd_zero");
    rd(MB + 32'hC, 32'h0000_0001, "status_rd");
    wr(MB + 32'hC, 4'hF, 32'h0000_0000);
    idle(1);
    check("w1c_zero_keeps", {31'd0, oob}, 32'd1);
    wr(MB + 32'hC, 4'b0001, 32'h0000_0001);
    idle(1);
    check("w1c_clear", {31'd0, oob}, 32'd0);
    // Unmapped MMIO: reads 0, write ignored, no oob
    wr(MB + 32'h10, 4'hF, 32'hFFFF_FFFF);
    rd(MB + 32'h10, 32'h0000_0000, "unmapped_rd");
    idle(1);
    check("unmapped_no_oob", {31'd0, oob}, 32'd0);
    // Clear immediately followed by out-of-range write leaves flag set
    wr(32'h0000_1004, 4'hF, 32'h1);
    wr(MB + 32'hC, 4'b0001, 32'h0000_0001);
    wr(32'h0000_2000, 4'hF, 32'h1);
    idle(1);
    check("set_after_clr", {31'd0, oob}, 32'd1);

    // Async reset in the middle of a read
    rd(32'h0000_0010, 32'h12BB_56DD, "pre_rst_rd");
    @(negedge clk);
    en = 1'b1; we = 4'd0; addr = 32'h0000_0000;
    #2;
    resetn = 1'b0;
    #1;
    check("arst_rdata", rdata, 32'd0);
    check("arst_led", {16'd0, led}, 32'd0);
    check("arst_oob", {31'd0, oob}, 32'd0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    rd(MB + 32'h8, 32'h0000_0001, "arst_timer");
    rd(32'h0000_0010, 32'h12BB_56DD, "ram_persist");
    rd(32'h0000_0000, 32'hCAFE_F00D, "ram_persist0");
    idle(3);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Responder for the CPU's data SRAM port. Sits on the far side of `data_sram_en/we/addr/wdata/rdata` at the SoC level and serves every CPU load/store with fixed one-cycle read latency. Provides a word-addressed RAM with byte-lane writes plus a small MMIO page: LED register, synchronised switch input, free-running timer and sticky status. No ready/stall signal exists on this interface, so every access completes in fixed time.

## Interface
- `RAM_WORDS`, default 1024: RAM depth in 32-bit words; a power of two.
- `MMIO_BASE`, default 32'hBFAF_0000: MMIO page base; only bits [31:16] are compared.
- `clk`  in  1  sole clock; all state on rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `data_sram_en`  in  1  access request this cycle.
- `data_sram_we`  in  4  byte-lane write enables; 0 means read.
- `data_sram_addr`  in  32  byte address; bits [1:0] ignored.
- `data_sram_wdata`  in  32  store data, lane-aligned.
- `data_sram_rdata`  out  32  registered read data.
- `led`  out  16  LED register value.
- `switch`  in  8  asynchronous board switches.
- `oob_err`  out  1  sticky out-of-range access flag.

## Operation
**Address decode** (only when `en`=1):
- MMIO when `addr[31:16]==MMIO_BASE[31:16]`; register offset is `addr[3:2]`; `addr[15:4]`≠0 is an unmapped MMIO address.
- Otherwise RAM, with word index = `addr[31:2]`.
- A RAM index ≥ `RAM_WORDS` is out of range:
  - writes are dropped;
  - reads return 0;
  - `oob_err` sets on the next edge.

**RAM**
- Write: each lane i with `we[i]`=1 updates byte i.
- Read: `rdata` ← word.
- Contents are not reset.

**MMIO map**
- 0x0 LED: RW, bits [15:0], lanes 0–1; upper lanes ignored; reads zero-extend.
- 0x4 SWITCH: RO; 2-flop synchroniser output, zero-extended; writes ignored.
- 0x8 TIMER: RW, 32-bit.
  - Increments every cycle and wraps 0xFFFF_FFFF→0.
  - Lane writes replace the enabled bytes; a write beats the increment that cycle.
  - A read returns the pre-edge value.
- 0xC STATUS: bit0 = `oob_err`; writing 1 to bit0 with `we[0]` clears it (W1C); other bits read 0.
  - Set and clear on the same edge: set wins.
- Unmapped MMIO addresses read 0; writes are ignored and do not set `oob_err`.

**Read data register**
- Loads only on a read (`en`=1, `we`=0).
- Holds its value on writes and on idle cycles.

## Timing
- Reset (async assert, deassert sampled on `clk`) drives:
  - `rdata`=0, `led`=0, timer=0, `oob_err`=0;
  - synchroniser flops=0.
- Read latency is 1 cycle: a read with `en`=1 at edge N makes `rdata` valid after edge N and held until the next read.
- Writes take effect at the edge they are sampled.
- Back-to-back accesses:
  - A read in cycle N+1 of a word written in cycle N returns the new data.
  - One access per cycle; no same-cycle read/write hazard is possible.
- Switch → SWITCH read path is 2 cycles through the synchroniser, plus 1 cycle read latency.
- Reset asserted mid-access: the in-flight read is lost and `rdata`=0 immediately.
  - RAM writes sampled before the assertion persist.
  - Timer/LED/status clear.
- `led` and `oob_err` are direct register outputs; no combinational path from inputs.

## Test plan
- Reset, then write 0x1234_5678 to 0x0000_0010 with `we`=4'hF; read it → `rdata`=0x1234_5678 one cycle later; `rdata` stays stable through 3 idle cycles.
- Lane merge: write 0xAABB_CCDD with `we`=4'b0101 over 0x1234_5678 → read returns 0x12BB_56DD.
- MMIO:
  - Write 0xFFFF_A5A5 to 0xBFAF_0000 → `led`=0xA5A5, read returns 0x0000_A5A5.
  - Switch=0x3C → SWITCH read returns 0x3C once ≥2 cycles have elapsed.
- Timer:
  - Write 0xFFFF_FFFE → two cycles later a read returns 0x0000_0000 (wrap).
  - Two reads 5 cycles apart differ by 5.
- Out of range (`RAM_WORDS`=1024): write to 0x0000_1000 → `oob_err`=1 and RAM word 0 is unchanged; read of the same address returns 0.
  - Write 1 to STATUS → `oob_err`=0.
  - Simultaneous out-of-range write and W1C ordering keeps the flag set.
- Assert `resetn`=0 asynchronously mid-read → `rdata`, `led`, timer and `oob_err` go to 0 without waiting for a clock edge; RAM data written before reset reads back intact afterwards.
